s_axi_reg_bank: RTL and testbench

//  Parametrised AXI4-Lite-style slave register bank, the successor to s_axi_reg.

---
 rtl/s_axi_reg_pkg.sv | 29 ++
 rtl/s_axi_reg_bank_wr.sv | 167 ++++++++++++++++
 rtl/s_axi_reg_bank.sv | 192 +++++++++++++++++++
 tb/tb_s_axi_reg_bank.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s_axi_reg_pkg.sv
// Shared types for the AXI4-Lite register bank: response codes and channel FSM states.
package s_axi_reg_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [0:0] {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    // Byte-lane merge used by the strobed register write.
    function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       en);
        logic [7:0] res;
        if (en) res = new_b;
        else    res = old_b;
        return res;
    endfunction

endpackage

// File: rtl/s_axi_reg_bank_wr.sv
// Write side of the register bank: independent AW/W capture, write FSM and B channel.
// Exposes a one-cycle commit strobe with decoded index, data and strobes to the top.
module s_axi_reg_bank_wr
    import s_axi_reg_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 32,
    parameter int              ID_W      = 4,
    parameter int              NUM_REGS  = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'hA3DD_0000,
    localparam int             IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                areset,
    input  logic [ID_W-1:0]     awid_i,
    input  logic [ADDR_W-1:0]   awaddr_i,
    input  logic                awvalid_i,
    output logic                awready_o,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                wvalid_i,
    output logic                wready_o,
    output logic [ID_W-1:0]     bid_o,
    output logic [1:0]          bresp_o,
    output logic                bvalid_o,
    input  logic                bready_i,
    output logic                wr_commit_o,
    output logic                wr_hit_o,
    output logic [IDX_W-1:0]    wr_idx_o,
    output logic [DATA_W-1:0]   wr_data_o,
    output logic [DATA_W/8-1:0] wr_strb_o
);

    localparam int LSB     = $clog2(DATA_W/8);
    localparam int TAG_LSB = LSB + IDX_W;

    wr_state_t              wr_state_r, wr_state_nxt_s;
    logic                   aw_held_r, aw_held_nxt_s;
    logic                   w_held_r, w_held_nxt_s;
    logic                   awready_r, awready_nxt_s;
    logic                   wready_r, wready_nxt_s;
    logic                   bvalid_r, bvalid_nxt_s;
    logic [ID_W-1:0]        bid_r;
    resp_t                  bresp_r;
    logic                   aw_hit_r;
    logic [IDX_W-1:0]       aw_idx_r;
    logic [ID_W-1:0]        aw_id_r;
    logic [DATA_W-1:0]      w_data_r;
    logic [DATA_W/8-1:0]    w_strb_r;
    logic                   aw_hs_s, w_hs_s, commit_s;

    if (LSB > 0) begin : g_lsb
        logic aw_unused_s;
        assign aw_unused_s = ^awaddr_i[LSB-1:0];
    end

    assign aw_hs_s  = awvalid_i && awready_r;
    assign w_hs_s   = wvalid_i && wready_r;
    assign commit_s = (wr_state_r == WR_IDLE) && aw_held_r && w_held_r;

    // Write FSM state register.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) wr_state_r <= WR_IDLE;
        else         wr_state_r <= wr_state_nxt_s;
    end

    // Write FSM next-state logic.
    always_comb begin
        wr_state_nxt_s = wr_state_r;
        case (wr_state_r)
            WR_IDLE: begin
                if (aw_held_r && w_held_r) wr_state_nxt_s = WR_RESP;
                else                       wr_state_nxt_s = WR_IDLE;
            end
            WR_RESP: begin
                if (bready_i) wr_state_nxt_s = WR_IDLE;
                else          wr_state_nxt_s = WR_RESP;
            end
            default: wr_state_nxt_s = WR_IDLE;
        endcase
    end

    // Write FSM output logic: next values of the held flags, readies and bvalid.
    always_comb begin
        aw_held_nxt_s = aw_held_r;
        w_held_nxt_s  = w_held_r;
        bvalid_nxt_s  = bvalid_r;
        case (wr_state_r)
            WR_IDLE: begin
                if (commit_s) begin
                    bvalid_nxt_s = 1'b1;
                end else begin
                    if (aw_hs_s) aw_held_nxt_s = 1'b1;
                    else         aw_held_nxt_s = aw_held_r;
                    if (w_hs_s)  w_held_nxt_s  = 1'b1;
                    else         w_held_nxt_s  = w_held_r;
                end
            end
            WR_RESP: begin
                if (bready_i) begin
                    bvalid_nxt_s  = 1'b0;
                    aw_held_nxt_s = 1'b0;
                    w_held_nxt_s  = 1'b0;
                end else begin
                    bvalid_nxt_s  = 1'b1;
                end
            end
            default: begin
                bvalid_nxt_s  = 1'b0;
                aw_held_nxt_s = 1'b0;
                w_held_nxt_s  = 1'b0;
            end
        endcase
        awready_nxt_s = (wr_state_nxt_s == WR_IDLE) && !aw_held_nxt_s;
        wready_nxt_s  = (wr_state_nxt_s == WR_IDLE) && !w_held_nxt_s;
    end

    // Channel capture and registered B-channel outputs.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bid_r     <= '0;
            bresp_r   <= OKAY;
            aw_hit_r  <= 1'b0;
            aw_idx_r  <= '0;
            aw_id_r   <= '0;
            w_data_r  <= '0;
            w_strb_r  <= '0;
        end else begin
            aw_held_r <= aw_held_nxt_s;
            w_held_r  <= w_held_nxt_s;
            awready_r <= awready_nxt_s;
            wready_r  <= wready_nxt_s;
            bvalid_r  <= bvalid_nxt_s;
            if (aw_hs_s) begin
                aw_hit_r <= (awaddr_i[ADDR_W-1:TAG_LSB] == BASE_ADDR[ADDR_W-1:TAG_LSB]);
                aw_idx_r <= awaddr_i[LSB +: IDX_W];
                aw_id_r  <= awid_i;
            end
            if (w_hs_s) begin
                w_data_r <= wdata_i;
                w_strb_r <= wstrb_i;
            end
            if (commit_s) begin
                bid_r <= aw_id_r;
                if (aw_hit_r) bresp_r <= OKAY;
                else          bresp_r <= SLVERR;
            end
        end
    end

    assign awready_o   = awready_r;
    assign wready_o    = wready_r;
    assign bvalid_o    = bvalid_r;
    assign bid_o       = bid_r;
    assign bresp_o     = bresp_r;
    assign wr_commit_o = commit_s;
    assign wr_hit_o    = aw_hit_r;
    assign wr_idx_o    = aw_idx_r;
    assign wr_data_o   = w_data_r;
    assign wr_strb_o   = w_strb_r;

endmodule

// File: rtl/s_axi_reg_bank.sv
// AXI4-Lite slave register bank: register array, read FSM and R channel; the write
// channels are handled by s_axi_reg_bank_wr. All register values are exported.
module s_axi_reg_bank
    import s_axi_reg_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                ID_W      = 4,
    parameter int                NUM_REGS  = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'hA3DD_0000,
    parameter logic [DATA_W-1:0] RST_VAL   = '0
) (
    input  logic                         clk,
    input  logic                         areset,
    input  logic [ID_W-1:0]              awid_i,
    input  logic [ADDR_W-1:0]            awaddr_i,
    input  logic                         awvalid_i,
    output logic                         awready_o,
    input  logic [DATA_W-1:0]            wdata_i,
    input  logic [DATA_W/8-1:0]          wstrb_i,
    input  logic                         wvalid_i,
    output logic                         wready_o,
    output logic [ID_W-1:0]              bid_o,
    output logic [1:0]                   bresp_o,
    output logic                         bvalid_o,
    input  logic                         bready_i,
    input  logic [ID_W-1:0]              arid_i,
    input  logic [ADDR_W-1:0]            araddr_i,
    input  logic                         arvalid_i,
    output logic                         arready_o,
    output logic [ID_W-1:0]              rid_o,
    output logic [DATA_W-1:0]            rdata_o,
    output logic [1:0]                   rresp_o,
    output logic                         rvalid_o,
    input  logic                         rready_i,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          wr_pulse_o
);

    localparam int LSB     = $clog2(DATA_W/8);
    localparam int IDX_W   = $clog2(NUM_REGS);
    localparam int TAG_LSB = LSB + IDX_W;

    logic [DATA_W-1:0]   regs_r [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_r, wr_pulse_nxt_s;
    logic                wr_commit_s, wr_hit_s;
    logic [IDX_W-1:0]    wr_idx_s;
    logic [DATA_W-1:0]   wr_data_s;
    logic [DATA_W/8-1:0] wr_strb_s;

    rd_state_t           rd_state_r, rd_state_nxt_s;
    logic                arready_r, arready_nxt_s;
    logic                rvalid_r, rvalid_nxt_s;
    logic [ID_W-1:0]     rid_r;
    logic [DATA_W-1:0]   rdata_r;
    resp_t               rresp_r;
    logic                ar_hs_s, rd_hit_s;
    logic [IDX_W-1:0]    rd_idx_s;

    s_axi_reg_bank_wr #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .ID_W      (ID_W),
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR)
    ) u_wr (
        .clk         (clk),
        .areset      (areset),
        .awid_i      (awid_i),
        .awaddr_i    (awaddr_i),
        .awvalid_i   (awvalid_i),
        .awready_o   (awready_o),
        .wdata_i     (wdata_i),
        .wstrb_i     (wstrb_i),
        .wvalid_i    (wvalid_i),
        .wready_o    (wready_o),
        .bid_o       (bid_o),
        .bresp_o     (bresp_o),
        .bvalid_o    (bvalid_o),
        .bready_i    (bready_i),
        .wr_commit_o (wr_commit_s),
        .wr_hit_o    (wr_hit_s),
        .wr_idx_o    (wr_idx_s),
        .wr_data_o   (wr_data_s),
        .wr_strb_o   (wr_strb_s)
    );

    if (LSB > 0) begin : g_lsb
        logic ar_unused_s;
        assign ar_unused_s = ^araddr_i[LSB-1:0];
    end

    assign ar_hs_s  = arvalid_i && arready_r;
    assign rd_hit_s = (araddr_i[ADDR_W-1:TAG_LSB] == BASE_ADDR[ADDR_W-1:TAG_LSB]);
    assign rd_idx_s = araddr_i[LSB +: IDX_W];

    // One-hot update pulse for the register being written with at least one strobe.
    always_comb begin
        wr_pulse_nxt_s = '0;
        if (wr_commit_s && wr_hit_s && (|wr_strb_s)) wr_pulse_nxt_s[wr_idx_s] = 1'b1;
        else                                          wr_pulse_nxt_s = '0;
    end

    // Register array with byte-strobed writes; a missed write touches nothing.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            for (int k = 0; k < NUM_REGS; k++) regs_r[k] <= RST_VAL;
            wr_pulse_r <= '0;
        end else begin
            wr_pulse_r <= wr_pulse_nxt_s;
            if (wr_commit_s && wr_hit_s) begin
                for (int b = 0; b < DATA_W/8; b++) begin
                    regs_r[wr_idx_s][b*8 +: 8] <= merge_byte(regs_r[wr_idx_s][b*8 +: 8],
                                                             wr_data_s[b*8 +: 8],
                                                             wr_strb_s[b]);
                end
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) rd_state_r <= RD_IDLE;
        else         rd_state_r <= rd_state_nxt_s;
    end

    // Read FSM next-state logic.
    always_comb begin
        rd_state_nxt_s = rd_state_r;
        case (rd_state_r)
            RD_IDLE: begin
                if (ar_hs_s) rd_state_nxt_s = RD_DATA;
                else         rd_state_nxt_s = RD_IDLE;
            end
            RD_DATA: begin
                if (rready_i) rd_state_nxt_s = RD_IDLE;
                else          rd_state_nxt_s = RD_DATA;
            end
            default: rd_state_nxt_s = RD_IDLE;
        endcase
    end

    // Read FSM output logic: arready/rvalid follow the next state.
    always_comb begin
        arready_nxt_s = 1'b0;
        rvalid_nxt_s  = 1'b0;
        case (rd_state_nxt_s)
            RD_IDLE: arready_nxt_s = 1'b1;
            RD_DATA: rvalid_nxt_s  = 1'b1;
            default: begin
                arready_nxt_s = 1'b0;
                rvalid_nxt_s  = 1'b0;
            end
        endcase
    end

    // R-channel registers; data is sampled from the pre-edge register contents.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rid_r     <= '0;
            rdata_r   <= '0;
            rresp_r   <= OKAY;
        end else begin
            arready_r <= arready_nxt_s;
            rvalid_r  <= rvalid_nxt_s;
            if (ar_hs_s) begin
                rid_r <= arid_i;
                if (rd_hit_s) begin
                    rdata_r <= regs_r[rd_idx_s];
                    rresp_r <= OKAY;
                end else begin
                    rdata_r <= '0;
                    rresp_r <= SLVERR;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign regs_o[k*DATA_W +: DATA_W] = regs_r[k];
    end

    assign arready_o  = arready_r;
    assign rvalid_o   = rvalid_r;
    assign rid_o      = rid_r;
    assign rdata_o    = rdata_r;
    assign rresp_o    = rresp_r;
    assign wr_pulse_o = wr_pulse_r;

endmodule

// File: tb/tb_s_axi_reg_bank.sv
// Self-checking bench for s_axi_reg_bank: expected B/R responses are queued when
// stimulus is driven and compared when the DUT presents them.
module tb_s_axi_reg_bank;

    localparam int DW = 32;
    localparam int NR = 8;

    logic            clk, areset;
    logic [3:0]      awid_i, arid_i, bid_o, rid_o;
    logic [31:0]     awaddr_i, araddr_i, wdata_i, rdata_o;
    logic [3:0]      wstrb_i;
    logic            awvalid_i, awready_o, wvalid_i, wready_o;
    logic [1:0]      bresp_o, rresp_o;
    logic            bvalid_o, bready_i, arvalid_i, arready_o, rvalid_o, rready_i;
    logic [NR*DW-1:0] regs_o;
    logic [NR-1:0]   wr_pulse_o;

    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; } r_exp_t;

    b_exp_t      b_q[$];
    r_exp_t      r_q[$];
    logic [31:0] model [NR];
    int          pulse_cnt [NR];
    int          errors = 0;
    int          checks = 0;

    s_axi_reg_bank dut (
        .clk(clk), .areset(areset),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .arid_i(arid_i), .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o),
        .rready_i(rready_i), .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int k = 0; k < NR; k++) if (wr_pulse_o[k]) pulse_cnt[k]++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    function automatic logic is_hit(input logic [31:0] a);
        return (a & 32'hFFFF_FFE0) == 32'hA3DD_0000;
    endfunction

    task automatic expect_write(input logic [31:0] a, input logic [3:0] id,
                                input logic [31:0] d, input logic [3:0] s);
        b_exp_t e;
        e.id   = id;
        e.resp = is_hit(a) ? 2'b00 : 2'b10;
        if (is_hit(a))
            for (int b = 0; b < 4; b++) if (s[b]) model[a[4:2]][b*8 +: 8] = d[b*8 +: 8];
        b_q.push_back(e);
    endtask

    task automatic expect_read(input logic [31:0] a, input logic [3:0] id);
        r_exp_t e;
        e.id   = id;
        e.data = is_hit(a) ? model[a[4:2]] : 32'h0;
        e.resp = is_hit(a) ? 2'b00 : 2'b10;
        r_q.push_back(e);
    endtask

    task automatic clear_pulses();
        for (int k = 0; k < NR; k++) pulse_cnt[k] = 0;
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < NR; k++) begin
            checks++;
            if (regs_o[k*DW +: DW] !== model[k]) begin
                errors++;
                $display("FAIL %s reg%0d: got %h expected %h", tag, k, regs_o[k*DW +: DW], model[k]);
            end
        end
    endtask

    task automatic check_pulses(input string tag, input int idx);
        for (int k = 0; k < NR; k++) begin
            checks++;
            if (pulse_cnt[k] !== ((k == idx) ? 1 : 0)) begin
                errors++;
                $display("FAIL %s pulse%0d: got %0d expected %0d", tag, k, pulse_cnt[k], (k == idx) ? 1 : 0);
            end
        end
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [3:0] id);
        int n = 0;
        @(negedge clk);
        awaddr_i = a; awid_i = id; awvalid_i = 1'b1;
        while (!awready_o && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!awready_o) begin errors++; $display("FAIL aw_timeout: awready got 0 expected 1"); end
        @(posedge clk); #1 awvalid_i = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge clk);
        wdata_i = d; wstrb_i = s; wvalid_i = 1'b1;
        while (!wready_o && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!wready_o) begin errors++; $display("FAIL w_timeout: wready got 0 expected 1"); end
        @(posedge clk); #1 wvalid_i = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [3:0] id);
        int n = 0;
        @(negedge clk);
        araddr_i = a; arid_i = id; arvalid_i = 1'b1;
        while (!arready_o && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!arready_o) begin errors++; $display("FAIL ar_timeout: arready got 0 expected 1"); end
        expect_read(a, id);
        @(posedge clk); #1 arvalid_i = 1'b0;
    endtask

    // AW and W presented together; checks the one-edge write latency.
    task automatic write_same(input logic [31:0] a, input logic [3:0] id,
                              input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge clk);
        awaddr_i = a; awid_i = id; wdata_i = d; wstrb_i = s;
        awvalid_i = 1'b1; wvalid_i = 1'b1;
        while (!(awready_o && wready_o) && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!(awready_o && wready_o)) begin
            errors++; $display("FAIL aw_w_timeout: ready got %b%b expected 11", awready_o, wready_o);
        end
        expect_write(a, id, d, s);
        @(posedge clk); #1 awvalid_i = 1'b0; wvalid_i = 1'b0;
        checks++;
        if (bvalid_o !== 1'b0) begin errors++; $display("FAIL bvalid_early: got %b expected 0", bvalid_o); end
        @(posedge clk); #1;
        checks++;
        if (bvalid_o !== 1'b1) begin errors++; $display("FAIL bvalid_latency: got %b expected 1", bvalid_o); end
    endtask

    task automatic collect_b(input string tag, input int hold);
        b_exp_t e;
        int n = 0;
        @(negedge clk);
        while (!bvalid_o && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!bvalid_o || b_q.size() == 0) begin
            errors++; $display("FAIL %s b_timeout: bvalid got %b expected 1", tag, bvalid_o);
        end else begin
            e = b_q.pop_front();
            for (int i = 0; i <= hold; i++) begin
                checks++;
                if (bvalid_o !== 1'b1 || bid_o !== e.id || bresp_o !== e.resp) begin
                    errors++;
                    $display("FAIL %s bresp: got v=%b id=%h resp=%b expected v=1 id=%h resp=%b",
                             tag, bvalid_o, bid_o, bresp_o, e.id, e.resp);
                end
                if (i < hold) @(negedge clk);
            end
        end
        bready_i = 1'b1;
        @(posedge clk); #1 bready_i = 1'b0;
        checks++;
        if (bvalid_o !== 1'b0) begin errors++; $display("FAIL %s b_drop: bvalid got %b expected 0", tag, bvalid_o); end
    endtask

    task automatic collect_r(input string tag, input int hold);
        r_exp_t e;
        int n = 0;
        @(negedge clk);
        while (!rvalid_o && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!rvalid_o || r_q.size() == 0) begin
            errors++; $display("FAIL %s r_timeout: rvalid got %b expected 1", tag, rvalid_o);
        end else begin
            e = r_q.pop_front();
            for (int i = 0; i <= hold; i++) begin
                checks++;
                if (rvalid_o !== 1'b1 || rid_o !== e.id || rdata_o !== e.data || rresp_o !== e.resp) begin
                    errors++;
                    $display("FAIL %s rdata: got v=%b id=%h data=%h resp=%b expected v=1 id=%h data=%h resp=%b",
                             tag, rvalid_o, rid_o, rdata_o, rresp_o, e.id, e.data, e.resp);
                end
                if (i < hold) @(negedge clk);
            end
        end
        rready_i = 1'b1;
        @(posedge clk); #1 rready_i = 1'b0;
        checks++;
        if (rvalid_o !== 1'b0 || arready_o !== 1'b1) begin
            errors++; $display("FAIL %s r_drop: rvalid/arready got %b%b expected 01", tag, rvalid_o, arready_o);
        end
    endtask

    task automatic test_reset();
        areset = 1'b0;
        awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0; bready_i = 1'b0; rready_i = 1'b0;
        awid_i = 4'h0; arid_i = 4'h0; awaddr_i = 32'h0; araddr_i = 32'h0;
        wdata_i = 32'h0; wstrb_i = 4'h0;
        for (int k = 0; k < NR; k++) model[k] = 32'h0;
        clear_pulses();
        repeat (3) @(negedge clk);
        checks++;
        if ({awready_o, wready_o, arready_o, bvalid_o, rvalid_o, wr_pulse_o} !== 13'h0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 0",
                               {awready_o, wready_o, arready_o, bvalid_o, rvalid_o, wr_pulse_o});
        end
        check_regs("reset");
        areset = 1'b1;
        #1;
        checks++;
        if ({awready_o, wready_o, arready_o} !== 3'b000) begin
            errors++; $display("FAIL ready_before_edge: got %b expected 000", {awready_o, wready_o, arready_o});
        end
        @(posedge clk); #1;
        checks++;
        if ({awready_o, wready_o, arready_o} !== 3'b111) begin
            errors++; $display("FAIL ready_after_edge: got %b expected 111", {awready_o, wready_o, arready_o});
        end
    endtask

    task automatic test_write_w_first();
        clear_pulses();
        send_w(32'hC2CC_EE2E, 4'hF);
        repeat (3) @(negedge clk);
        send_aw(32'hA3DD_0004, 4'h5);
        expect_write(32'hA3DD_0004, 4'h5, 32'hC2CC_EE2E, 4'hF);
        collect_b("w_first", 2);
        check_regs("w_first");
        check_pulses("w_first", 1);
    endtask

    task automatic test_write_strobe();
        write_same(32'hA3DD_0008, 4'h2, 32'hFFFF_FFFF, 4'hF);
        collect_b("preset", 0);
        clear_pulses();
        write_same(32'hA3DD_0008, 4'h7, 32'h7778_111A, 4'b0101);
        collect_b("strobe", 0);
        checks++;
        if (regs_o[95:64] !== 32'hFF78_FF1A) begin
            errors++; $display("FAIL strobe_reg2: got %h expected ff78ff1a", regs_o[95:64]);
        end
        check_regs("strobe");
        check_pulses("strobe", 2);
        clear_pulses();
        write_same(32'hA3DD_0008, 4'h1, 32'h1234_5678, 4'b0000);
        collect_b("nostrb", 0);
        check_regs("nostrb");
        check_pulses("nostrb", -1);
    endtask

    task automatic test_read_backpressure();
        send_ar(32'hA3DD_0004, 4'h3);
        collect_r("rd_hold", 5);
        send_ar(32'hA3DD_0009, 4'hA);
        collect_r("rd_lowbits", 0);
    endtask

    task automatic test_miss();
        clear_pulses();
        write_same(32'hA3DE_0000, 4'h6, 32'hDEAD_BEEF, 4'hF);
        collect_b("wr_miss", 0);
        send_ar(32'h0000_0010, 4'h9);
        collect_r("rd_miss", 0);
        check_regs("miss");
        check_pulses("miss", -1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < NR; k++) begin
            write_same(32'hA3DD_0000 + 32'(k*4), 4'(k), 32'h5A00_0000 + 32'(k*32'h0101), 4'hF);
            collect_b("b2b_wr", 0);
        end
        for (int k = NR - 1; k >= 0; k--) begin
            send_ar(32'hA3DD_0000 + 32'(k*4), 4'(15 - k));
            collect_r("b2b_rd", 0);
        end
        check_regs("b2b");
    endtask

    // Read handshake on the same edge as the write commit must see the old value.
    task automatic test_collision();
        int n = 0;
        @(negedge clk);
        awaddr_i = 32'hA3DD_0014; awid_i = 4'hC; wdata_i = 32'h0BAD_F00D; wstrb_i = 4'hF;
        awvalid_i = 1'b1; wvalid_i = 1'b1;
        while (!(awready_o && wready_o) && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 awvalid_i = 1'b0; wvalid_i = 1'b0;
        @(negedge clk);
        araddr_i = 32'hA3DD_0014; arid_i = 4'hD; arvalid_i = 1'b1;
        checks++;
        if (arready_o !== 1'b1) begin errors++; $display("FAIL coll_arready: got %b expected 1", arready_o); end
        expect_read(32'hA3DD_0014, 4'hD);
        expect_write(32'hA3DD_0014, 4'hC, 32'h0BAD_F00D, 4'hF);
        @(posedge clk); #1 arvalid_i = 1'b0;
        collect_r("collision", 0);
        collect_b("collision", 0);
        check_regs("collision");
    endtask

    task automatic test_reset_in_flight();
        write_same(32'hA3DD_000C, 4'h4, 32'h1357_9BDF, 4'hF);
        @(negedge clk);
        areset = 1'b0;
        #1;
        b_q.delete();
        for (int k = 0; k < NR; k++) model[k] = 32'h0;
        checks++;
        if ({bvalid_o, awready_o, wready_o, arready_o} !== 4'b0000) begin
            errors++; $display("FAIL rst_flight: bvalid/readies got %b expected 0000",
                               {bvalid_o, awready_o, wready_o, arready_o});
        end
        check_regs("rst_flight");
        repeat (2) @(negedge clk);
        areset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bvalid_o !== 1'b0 || awready_o !== 1'b1) begin
            errors++; $display("FAIL rst_release: bvalid/awready got %b%b expected 01", bvalid_o, awready_o);
        end
        clear_pulses();
        write_same(32'hA3DD_001C, 4'hE, 32'hCAFE_0001, 4'hF);
        collect_b("post_rst", 0);
        check_regs("post_rst");
        check_pulses("post_rst", 7);
    endtask

    initial begin
        test_reset();
        test_write_w_first();
        test_write_strobe();
        test_read_backpressure();
        test_miss();
        test_back_to_back();
        test_collision();
        test_reset_in_flight();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
